// File: rtl/rdysetgo_test.sv
// rdysetgo_test: READY/SET/GO reaction game driving a scanned 4-digit 7-segment display.
// Define RDYSETGO_HISCORE_EN to keep a hiscore that is shown in IDLE and FAIL.
module rdysetgo_test #(
   parameter int unsigned PHASE_TICKS   = 100000000,
   parameter int unsigned REFRESH_TICKS = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Go,
   input  logic [1:0] correct,
   output logic [3:0] an,
   output logic [6:0] seg
);

   localparam int unsigned PW = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
   localparam int unsigned RW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
   localparam logic [PW-1:0] PHASE_LAST   = PW'(PHASE_TICKS - 1);
   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_TICKS - 1);

   // Character codes: 0..9 are the decimal digits themselves.
   localparam logic [4:0] C_BLANK = 5'd10;
   localparam logic [4:0] C_DASH  = 5'd11;
   localparam logic [4:0] C_R     = 5'd12;
   localparam logic [4:0] C_D     = 5'd13;
   localparam logic [4:0] C_Y     = 5'd14;
   localparam logic [4:0] C_S     = 5'd15;
   localparam logic [4:0] C_E     = 5'd16;
   localparam logic [4:0] C_T     = 5'd17;
   localparam logic [4:0] C_G     = 5'd18;
   localparam logic [4:0] C_O     = 5'd19;
   localparam logic [4:0] C_F     = 5'd20;
   localparam logic [4:0] C_A     = 5'd21;
   localparam logic [4:0] C_I     = 5'd22;
   localparam logic [4:0] C_L     = 5'd23;

   typedef enum logic [2:0] {IDLE, READY, SET, GOSHOW, PLAY, FAIL} state_t;

   state_t        state_q;
   logic [PW-1:0] timer_q;
   logic [3:0]    tens_q, ones_q;
   logic          go_s1_q, go_s2_q, go_s3_q;
   logic [1:0]    cor_q, cor_prev_q;
   logic [RW-1:0] rcnt_q;
   logic [1:0]    digit_q;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          start, step_evt, fail_evt, at_max;
   logic [4:0]    ch;
`ifdef RDYSETGO_HISCORE_EN
   logic [7:0]    hi_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         go_s1_q    <= 1'b0;
         go_s2_q    <= 1'b0;
         go_s3_q    <= 1'b0;
         cor_q      <= '0;
         cor_prev_q <= '0;
      end else begin
         go_s1_q    <= Go;
         go_s2_q    <= go_s1_q;
         go_s3_q    <= go_s2_q;
         cor_q      <= correct;
         cor_prev_q <= cor_q;
      end
   end

   always_comb begin
      start    = go_s2_q & ~go_s3_q;
      step_evt = (cor_q == 2'b01) && (cor_prev_q != 2'b01);
      fail_evt = (cor_q == 2'b10) && (cor_prev_q != 2'b10);
      at_max   = (tens_q == 4'd9) && (ones_q == 4'd9);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         timer_q <= '0;
         tens_q  <= '0;
         ones_q  <= '0;
`ifdef RDYSETGO_HISCORE_EN
         hi_q    <= '0;
`endif
      end else begin
         case (state_q)
            IDLE, FAIL: begin
               if (start) begin
                  state_q <= READY;
                  timer_q <= '0;
                  tens_q  <= '0;
                  ones_q  <= '0;
               end
            end
            READY, SET, GOSHOW: begin
               if (timer_q == PHASE_LAST) begin
                  timer_q <= '0;
                  case (state_q)
                     READY:   state_q <= SET;
                     SET:     state_q <= GOSHOW;
                     default: state_q <= PLAY;
                  endcase
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            PLAY: begin
               if (step_evt && !fail_evt) begin
                  // Score is kept in BCD so the display needs no conversion.
                  if (!at_max) begin
                     if (ones_q == 4'd9) begin
                        ones_q <= '0;
                        tens_q <= tens_q + 4'd1;
                     end else begin
                        ones_q <= ones_q + 4'd1;
                     end
                  end
               end else if (fail_evt && !step_evt) begin
                  state_q <= FAIL;
`ifdef RDYSETGO_HISCORE_EN
                  if ({tens_q, ones_q} > hi_q) hi_q <= {tens_q, ones_q};
`endif
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   function automatic logic [4:0] tens_ch(input logic [3:0] d);
      return (d == 4'd0) ? C_BLANK : {1'b0, d};
   endfunction

   // Active-high pattern {g,f,e,d,c,b,a}.
   function automatic logic [6:0] glyph(input logic [4:0] c);
      case (c)
         5'd0:    return 7'b0111111;
         5'd1:    return 7'b0000110;
         5'd2:    return 7'b1011011;
         5'd3:    return 7'b1001111;
         5'd4:    return 7'b1100110;
         5'd5:    return 7'b1101101;
         5'd6:    return 7'b1111101;
         5'd7:    return 7'b0000111;
         5'd8:    return 7'b1111111;
         5'd9:    return 7'b1101111;
         C_DASH:  return 7'b1000000;
         C_R:     return 7'b1010000;
         C_D:     return 7'b1011110;
         C_Y:     return 7'b1101110;
         C_S:     return 7'b1101101;
         C_E:     return 7'b1111001;
         C_T:     return 7'b1111000;
         C_G:     return 7'b0111101;
         C_O:     return 7'b1011100;
         C_F:     return 7'b1110001;
         C_A:     return 7'b1110111;
         C_I:     return 7'b0000110;
         C_L:     return 7'b0111000;
         default: return 7'b0000000;
      endcase
   endfunction

   // digit_q 3 is the leftmost character.
   always_comb begin
      ch = C_BLANK;
      case (state_q)
         IDLE: begin
`ifdef RDYSETGO_HISCORE_EN
            case (digit_q)
               2'd3:    ch = tens_ch(hi_q[7:4]);
               2'd2:    ch = {1'b0, hi_q[3:0]};
               default: ch = C_DASH;
            endcase
`else
            ch = C_DASH;
`endif
         end
         READY: begin
            case (digit_q)
               2'd3:    ch = C_R;
               2'd2:    ch = C_D;
               2'd1:    ch = C_Y;
               default: ch = C_BLANK;
            endcase
         end
         SET: begin
            case (digit_q)
               2'd3:    ch = C_S;
               2'd2:    ch = C_E;
               2'd1:    ch = C_T;
               default: ch = C_BLANK;
            endcase
         end
         GOSHOW: begin
            case (digit_q)
               2'd3:    ch = C_G;
               2'd2:    ch = C_O;
               default: ch = C_BLANK;
            endcase
         end
         PLAY: begin
            case (digit_q)
               2'd1:    ch = tens_ch(tens_q);
               2'd0:    ch = {1'b0, ones_q};
               default: ch = C_BLANK;
            endcase
         end
         FAIL: begin
`ifdef RDYSETGO_HISCORE_EN
            case (digit_q)
               2'd3:    ch = tens_ch(hi_q[7:4]);
               2'd2:    ch = {1'b0, hi_q[3:0]};
               2'd1:    ch = tens_ch(tens_q);
               default: ch = {1'b0, ones_q};
            endcase
`else
            case (digit_q)
               2'd3:    ch = C_F;
               2'd2:    ch = C_A;
               2'd1:    ch = C_I;
               default: ch = C_L;
            endcase
`endif
         end
         default: ch = C_BLANK;
      endcase
      seg_d = ~glyph(ch);
      an_d  = ~(4'b0001 << digit_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rcnt_q  <= '0;
         digit_q <= '0;
         an_q    <= '1;
         seg_q   <= '1;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         if (rcnt_q == REFRESH_LAST) begin
            rcnt_q  <= '0;
            digit_q <= digit_q + 2'd1;
         end else begin
            rcnt_q <= rcnt_q + 1'b1;
         end
      end
   end

   assign an  = an_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_rdysetgo_test.sv
// Self-checking bench for rdysetgo_test; compares the scanned display against a
// game-level model. Build with RDYSETGO_HISCORE_EN defined to cover the hiscore variant.
module tb_rdysetgo_test;

   localparam int unsigned PT = 4;
   localparam int unsigned RT = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       Go;
   logic [1:0] correct;
   logic [3:0] an;
   logic [6:0] seg;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   typedef enum {M_IDLE, M_READY, M_SET, M_GO, M_PLAY, M_FAIL} mstate_t;
   mstate_t m_state;
   int      m_score;
   int      m_hi;

   rdysetgo_test #(.PHASE_TICKS(PT), .REFRESH_TICKS(RT)) dut (
      .clk     (clk),
      .reset   (reset),
      .Go      (Go),
      .correct (correct),
      .an      (an),
      .seg     (seg)
   );

   always #5 clk = ~clk;

   // Active-low segment pattern from the list of lit segment letters.
   function automatic logic [6:0] seg_of(byte c);
      string on;
      logic [6:0] r;
      case (c)
         "0": on = "abcdef";  "1": on = "bc";      "2": on = "abdeg";
         "3": on = "abcdg";   "4": on = "bcfg";    "5": on = "acdfg";
         "6": on = "acdefg";  "7": on = "abc";     "8": on = "abcdefg";
         "9": on = "abcdfg";  "-": on = "g";       "r": on = "eg";
         "d": on = "bcdeg";   "y": on = "bcdfg";   "S": on = "acdfg";
         "E": on = "adefg";   "t": on = "defg";    "G": on = "acdef";
         "o": on = "cdeg";    "F": on = "aefg";    "A": on = "abcefg";
         "I": on = "bc";      "L": on = "def";     " ": on = "";
         default: return 7'bxxxxxxx;
      endcase
      r = '1;
      for (int i = 0; i < on.len(); i++) r[int'(on[i]) - 97] = 1'b0;
      return r;
   endfunction

   function automatic string text_for(mstate_t s, int sc, int hi);
      case (s)
`ifdef RDYSETGO_HISCORE_EN
         M_IDLE:  return $sformatf("%2d--", hi);
         M_FAIL:  return $sformatf("%2d%2d", hi, sc);
`else
         M_IDLE:  return "----";
         M_FAIL:  return "FAIL";
`endif
         M_READY: return "rdy ";
         M_SET:   return "SEt ";
         M_GO:    return "Go  ";
         default: return $sformatf("  %2d", sc);
      endcase
   endfunction

   function automatic logic [27:0] expect_of(string t);
      return {seg_of(t[0]), seg_of(t[1]), seg_of(t[2]), seg_of(t[3])};
   endfunction

   // Expected glyph for whichever single digit the anodes enable.
   function automatic logic [6:0] pick(string t, logic [3:0] a);
      case (a)
         4'b0111: return seg_of(t[0]);
         4'b1011: return seg_of(t[1]);
         4'b1101: return seg_of(t[2]);
         4'b1110: return seg_of(t[3]);
         default: return 7'bxxxxxxx;
      endcase
   endfunction

   // Game phase after j clock edges, counting from the Go rise.
   function automatic mstate_t phase_at(int j);
      int idx;
      if (j < 3) return M_IDLE;
      idx = (j - 3) / PT;
      case (idx)
         0:       return M_READY;
         1:       return M_SET;
         2:       return M_GO;
         default: return M_PLAY;
      endcase
   endfunction

   task automatic capture(output logic [27:0] got);
      got = 'x;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         case (an)
            4'b0111: got[27:21] = seg;
            4'b1011: got[20:14] = seg;
            4'b1101: got[13:7]  = seg;
            4'b1110: got[6:0]   = seg;
            default: ;
         endcase
      end
   endtask

   task automatic start_round();
      @(negedge clk); Go = 1'b1;
      repeat (2) @(negedge clk);
      Go = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      m_state = M_PLAY;
      m_score = 0;
   endtask

   task automatic step_pulses(int n, bit rnd);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); correct = 2'b01;
         repeat (rnd ? $urandom_range(2, 1) : 1) @(negedge clk);
         correct = (rnd && $urandom_range(1, 0) == 1) ? 2'b11 : 2'b00;
         repeat (rnd ? $urandom_range(2, 1) - 1 : 0) @(negedge clk);
         if (m_state == M_PLAY) m_score = (m_score < 99) ? m_score + 1 : 99;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic fail_pulse();
      @(negedge clk); correct = 2'b10;
      @(negedge clk); correct = 2'b00;
      repeat (3) @(negedge clk);
      if (m_state == M_PLAY) begin
         m_state = M_FAIL;
         if (m_score > m_hi) m_hi = m_score;
      end
   endtask

   task automatic test_reset();
      logic [27:0] got, exp;
      reset = 1'b1; Go = 1'b0; correct = 2'b00;
      m_state = M_IDLE; m_score = 0; m_hi = 0;
      #1 reset = 1'b0;
      #1;
      n_tests++;
      if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b expected 1111", an); end
      n_tests++;
      if (seg !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg: got %b expected 1111111", seg); end
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({an, seg} !== 11'h7FF) begin n_fail++; $display("FAIL reset_hold: got %b_%b expected all ones", an, seg); end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (an !== 4'b1110) begin n_fail++; $display("FAIL first_digit_an: got %b expected 1110", an); end
      n_tests++;
      if (seg !== pick(text_for(m_state, m_score, m_hi), 4'b1110)) begin
         n_fail++; $display("FAIL first_digit_seg: got %b expected %b", seg, pick(text_for(m_state, m_score, m_hi), 4'b1110));
      end
      capture(got);
      exp = expect_of(text_for(m_state, m_score, m_hi));
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL idle_display: got %h expected %h", got, exp); end
   endtask

   task automatic test_phases();
      logic [27:0] got, exp;
      logic [6:0]  e;
      @(negedge clk); Go = 1'b1; correct = 2'b00;
      for (int k = 1; k <= 17; k++) begin
         @(posedge clk); #1;
         e = pick(text_for(phase_at(k - 1), 0, m_hi), an);
         n_tests++;
         if (seg !== e) begin
            n_fail++; $display("FAIL phase_timing edge %0d: got an=%b seg=%b expected seg=%b", k, an, seg, e);
         end
         @(negedge clk);
         correct = (k >= 3 && k <= 9 && (k == 5 || $urandom_range(1, 0) == 1)) ? 2'b01 : 2'b00;
      end
      m_state = M_PLAY; m_score = 0;
      Go = 1'b0;
      repeat (2) @(negedge clk);
      Go = 1'b1;
      repeat (6) @(negedge clk);
      capture(got);
      exp = expect_of(text_for(m_state, m_score, m_hi));
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL ignored_inputs: got %h expected %h", got, exp); end
      @(negedge clk); Go = 1'b0;
   endtask

   task automatic test_score_fail();
      logic [27:0] got, exp;
      step_pulses(6, 1'b0);
      capture(got);
      exp = expect_of(text_for(m_state, m_score, m_hi));
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL score6: got %h expected %h", got, exp); end
      fail_pulse();
      capture(got);
      exp = expect_of(text_for(m_state, m_score, m_hi));
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL fail_display: got %h expected %h", got, exp); end
   endtask

   task automatic test_restart_saturate();
      logic [27:0] got, exp;
      for (int r = 0; r < 2; r++) begin
         @(negedge clk); Go = 1'b1;
         repeat (3) @(posedge clk);
         m_state = M_READY; m_score = 0;
         capture(got);
         exp = expect_of(text_for(m_state, m_score, m_hi));
         n_tests++;
         if (got !== exp) begin n_fail++; $display("FAIL restart_ready %0d: got %h expected %h", r, got, exp); end
         @(negedge clk); Go = 1'b0;
         repeat (9) @(negedge clk);
         m_state = M_PLAY;
         capture(got);
         exp = expect_of(text_for(m_state, m_score, m_hi));
         n_tests++;
         if (got !== exp) begin n_fail++; $display("FAIL restart_score0 %0d: got %h expected %h", r, got, exp); end
         if (r == 0) begin
            step_pulses(100, 1'b1);
            capture(got);
            exp = expect_of(text_for(m_state, m_score, m_hi));
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL saturate99: got %h expected %h", got, exp); end
         end
         fail_pulse();
      end
   endtask

   task automatic test_random_rounds();
      logic [27:0] got, exp;
      int n;
      for (int r = 0; r < 3; r++) begin
         start_round();
         n = $urandom_range(20, 0);
         step_pulses(n, 1'b1);
         capture(got);
         exp = expect_of(text_for(m_state, m_score, m_hi));
         n_tests++;
         if (got !== exp) begin n_fail++; $display("FAIL random_play %0d (n=%0d): got %h expected %h", r, n, got, exp); end
         fail_pulse();
         capture(got);
         exp = expect_of(text_for(m_state, m_score, m_hi));
         n_tests++;
         if (got !== exp) begin n_fail++; $display("FAIL random_fail %0d: got %h expected %h", r, got, exp); end
      end
   endtask

   task automatic test_reset_midround();
      logic [27:0] got, exp;
      start_round();
      step_pulses(4, 1'b1);
      @(posedge clk); #3;
      reset = 1'b0; correct = 2'b00; Go = 1'b0;
      #1;
      n_tests++;
      if ({an, seg} !== 11'h7FF) begin n_fail++; $display("FAIL midround_reset: got %b_%b expected all ones", an, seg); end
      m_state = M_IDLE; m_score = 0; m_hi = 0;
      @(negedge clk); @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (an !== 4'b1110) begin n_fail++; $display("FAIL midround_first_an: got %b expected 1110", an); end
      capture(got);
      exp = expect_of(text_for(m_state, m_score, m_hi));
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL midround_idle: got %h expected %h", got, exp); end
      start_round();
      capture(got);
      exp = expect_of(text_for(m_state, m_score, m_hi));
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL midround_no_residue: got %h expected %h", got, exp); end
   endtask

`ifdef RDYSETGO_HISCORE_EN
   task automatic test_hiscore();
      logic [27:0] got, exp;
      step_pulses(5, 1'b0);
      fail_pulse();
      start_round();
      step_pulses(3, 1'b0);
      fail_pulse();
      capture(got);
      exp = expect_of(" 5 3");
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL hiscore_5_3: got %h expected %h", got, exp); end
   endtask
`endif

   initial begin
      test_reset();
      test_phases();
      test_score_fail();
      test_restart_saturate();
      test_random_rounds();
      test_reset_midround();
`ifdef RDYSETGO_HISCORE_EN
      test_hiscore();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rdysetgo_test.md
RDYSETGO_TEST -- requirements
Module: rdysetgo_test

Interface
REQ-001 Parameter PHASE_TICKS, default 100000000, meaning clock cycles per READY/SET/GO phase (1 s at 100 MHz).
REQ-002 Parameter REFRESH_TICKS, default 100000, meaning clock cycles each display digit stays enabled.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Go  input  1  asynchronous start request; starts a round on its rising edge.
REQ-006 correct  input  2  player result: 01 = correct step, 10 = wrong step; 00 and 11 = no event.
REQ-007 an  output  4  digit anodes, active-low, one-hot; an[3] is the leftmost digit.
REQ-008 seg  output  7  segments seg[0:6] = a..g, active-low.

Function
REQ-009 Go SHALL pass a 2-flop synchronizer followed by rising-edge detection; a start pulse occurs on the 3rd rising clk edge after Go rises (setup met).
REQ-010 correct SHALL be registered once; an event fires only on the cycle its registered value changes to 01 (step) or to 10 (fail).
REQ-011 FSM states SHALL be IDLE, READY, SET, GOSHOW, PLAY and FAIL; the reset state is IDLE.
REQ-012 A start pulse in IDLE or FAIL SHALL clear score to 0, clear the phase timer and enter READY; start pulses in any other state SHALL be ignored.
REQ-013 READY, SET and GOSHOW SHALL each last exactly PHASE_TICKS cycles, advancing READY->SET->GOSHOW->PLAY.
REQ-014 correct events outside PLAY SHALL be ignored.
REQ-015 In PLAY, a step event SHALL increment score (0..99, saturating at 99); a fail event SHALL enter FAIL with score frozen.
REQ-016 If step and fail events occur in the same cycle (impossible by encoding 11), no action SHALL be taken.
REQ-017 Display text, left to right: IDLE "----"; READY "rdy "; SET "SEt "; GOSHOW "Go  "; PLAY "  " followed by score as two BCD digits, with the tens digit blank when below 10; FAIL "FAIL".
REQ-018 The digit scan SHALL cycle an = 1110, 1101, 1011, 0111, advancing every REFRESH_TICKS cycles, with seg showing the glyph for the enabled digit.
REQ-019 A blank digit SHALL drive seg = 1111111 while its anode is still scanned.
REQ-020 Outputs an and seg SHALL be registered.

Reset
REQ-021 While reset = 0, outputs SHALL immediately be an = 1111 and seg = 1111111.
REQ-022 While reset = 0, state SHALL be IDLE, score 0, phase timer and scan counter 0, and synchronizer and correct registers 0.
REQ-023 Reset asserted mid-round SHALL abort the round with no residue.
REQ-024 After reset release, the first scan digit SHALL be an = 1110.

Configuration
REQ-025 Macro RDYSETGO_HISCORE_EN.
- Defined: a hiscore register (reset 0) is updated to max(hiscore, score) on entry to FAIL; IDLE and FAIL show hiscore in the left two digits and score in the right two; IDLE shows "--" on the right.
- Undefined: no hiscore register; displays as in REQ-017.

Verification
REQ-026 Bench parameters for all scenarios: PHASE_TICKS = 4, REFRESH_TICKS = 1, clk period 10 ns.
REQ-027 reset = 0 at 1 ns -> an = 1111 and seg = 1111111 before the next clk edge; state IDLE.
REQ-028 Go pulse from IDLE -> READY 3 edges later, then SET after 4 cycles, GOSHOW after 4 more, and PLAY after 4 more.
REQ-029 Six 01 pulses (each separated by 00) in PLAY, then 10 -> score 6 displayed as " 6", then FAIL shows "FAIL".
REQ-030 01 pulses during READY/SET/GOSHOW, and Go held high during PLAY -> score stays 0 and the state is unchanged.
REQ-031 100 step events -> score saturates at 99; a Go pulse in FAIL -> score 0 and state READY.
REQ-032 With RDYSETGO_HISCORE_EN: round scores 5 then 3 -> hiscore 5 shown in the left digits during the second FAIL.
